// File: rtl/stim_pkg.sv
// Shared types for the stimulus sequencer: run modes, FSM states, Gray helper.
package stim_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_GRAY  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    // Binary-reflected Gray code of a (zero-extended) binary value.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// Vector handshake bundle between the sequencer (master) and the consumer (slave).
interface stim_sequencer_if #(
    parameter int WIDTH = 5
) ();

    logic [WIDTH-1:0] stim;
    logic             stim_valid;
    logic             stim_ready;
    logic [WIDTH:0]   vec_idx;

    modport master (
        output stim,
        output stim_valid,
        output vec_idx,
        input  stim_ready
    );

    modport slave (
        input  stim,
        input  stim_valid,
        input  vec_idx,
        output stim_ready
    );

endinterface

// File: rtl/stim_lfsr.sv
// Fibonacci LFSR: shifts left, new LSB is the parity of the tapped bits.
// A zero seed is replaced by 1 so the register never locks up.
module stim_lfsr #(
    parameter int               WIDTH     = 5,
    parameter logic [WIDTH-1:0] LFSR_POLY = 5'b10100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: load has priority over step.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
        end else if (step) begin
            q_d = {q_q[WIDTH-2:0], ^(q_q & LFSR_POLY)};
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: emits COUNT / GRAY / WALK1 / LFSR vector runs on a
// valid/ready handshake with a programmable idle gap between transfers.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter int               HOLD_W    = 8,
    parameter logic [WIDTH-1:0] LFSR_POLY = 5'b10100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [HOLD_W-1:0] hold,
    input  logic [WIDTH-1:0]  seed,
    output logic              busy,
    output logic              done,
    stim_sequencer_if.master  bus
);

    state_e            state_q, state_d;
    mode_e             mode_q,  mode_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [HOLD_W-1:0] gap_q,   gap_d;
    logic [WIDTH:0]    idx_q,   idx_d;
    logic [WIDTH-1:0]  cnt_q,   cnt_d;
    logic [WIDTH-1:0]  walk_q,  walk_d;
    logic [WIDTH:0]    last_idx;
    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  gray_w;
    logic              load_run;
    logic              advance;

    // Index of the final vector for the captured mode (N-1).
    always_comb begin
        case (mode_q)
            MODE_COUNT, MODE_GRAY: last_idx = {1'b0, {WIDTH{1'b1}}};
            MODE_WALK1:            last_idx = (WIDTH+1)'(WIDTH-1);
            default:               last_idx = {1'b0, {(WIDTH-1){1'b1}}, 1'b0};
        endcase
    end

    // Run control: capture on start, step vectors on transfer, time the gap.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        load_run = 1'b0;
        advance  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    mode_d   = mode_e'(mode);
                    hold_d   = hold;
                    idx_d    = '0;
                    load_run = 1'b1;
                end
            end
            S_DRIVE: begin
                if (bus.stim_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = S_FIN;
                    end else begin
                        // The vector steps on the transfer itself; during a
                        // gap valid is low so the early change is invisible.
                        advance = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        if (hold_q != '0) begin
                            state_d = S_GAP;
                            gap_d   = hold_q;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == HOLD_W'(1)) state_d = S_DRIVE;
                else                     gap_d   = gap_q - 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Vector generators for the counting and walking modes.
    always_comb begin
        cnt_d  = cnt_q;
        walk_d = walk_q;
        if (load_run) begin
            cnt_d  = '0;
            walk_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (advance) begin
            cnt_d  = cnt_q + 1'b1;
            walk_d = walk_q << 1;
        end
    end

    // All state clears asynchronously, so outputs drop to 0 without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COUNT;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            walk_q  <= walk_d;
        end
    end

    stim_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_POLY (LFSR_POLY)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load_run),
        .seed (seed),
        .step (advance),
        .q    (lfsr_q)
    );

    assign gray_w = WIDTH'(bin2gray(32'(cnt_q)));

    // Output vector selected by the captured mode.
    always_comb begin
        case (mode_q)
            MODE_COUNT: bus.stim = cnt_q;
            MODE_GRAY:  bus.stim = gray_w;
            MODE_WALK1: bus.stim = walk_q;
            default:    bus.stim = lfsr_q;
        endcase
    end

    assign bus.stim_valid = (state_q == S_DRIVE);
    assign bus.vec_idx    = idx_q;
    assign busy           = (state_q == S_DRIVE) || (state_q == S_GAP);
    assign done           = (state_q == S_FIN);

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer (WIDTH=5, LFSR_POLY=5'b10100).
module tb_stim_sequencer;

    localparam int W  = 5;
    localparam int HW = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode  = 2'd0;
    logic [HW-1:0] hold  = '0;
    logic [W-1:0]  seed  = '0;
    logic          busy;
    logic          done;

    stim_sequencer_if #(.WIDTH(W)) bus ();

    stim_sequencer #(
        .WIDTH     (W),
        .HOLD_W    (HW),
        .LFSR_POLY (5'b10100)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .hold  (hold),
        .seed  (seed),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        int           m;
        int           h;
        logic [W-1:0] sd;
        bit           scramble;
        int           n;
        logic [W-1:0] first;
        logic [W-1:0] last;
        int           busy_cyc;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected vector list, straight from the sequence definitions.
    task automatic gen_seq(input int m, input logic [W-1:0] sd);
        logic [W-1:0] s;
        exp_q.delete();
        case (m)
            0: for (int i = 0; i < 32; i++) exp_q.push_back(W'(i));
            1: for (int i = 0; i < 32; i++) exp_q.push_back(W'(i ^ (i >> 1)));
            2: for (int i = 0; i < W; i++)  exp_q.push_back(W'(1 << i));
            default: begin
                s = (sd == '0) ? W'(1) : sd;
                for (int i = 0; i < 31; i++) begin
                    exp_q.push_back(s);
                    s = {s[W-2:0], s[4] ^ s[2]};
                end
            end
        endcase
    endtask

    // Run one sequence with a cycle-by-cycle expectation of the handshake.
    task automatic run_seq(input int m, input int h, input logic [W-1:0] sd,
                           input int rpct, input bit scramble,
                           output int nx, output logic [W-1:0] first,
                           output logic [W-1:0] last, output int busy_cyc);
        int           k;
        int           gap;
        bit           fin;
        bit           saw_done;
        bit           rdy;
        logic [W-1:0] prev;
        bit           seen[32];
        gen_seq(m, sd);
        nx = 0; busy_cyc = 0; k = 0; gap = 0; fin = 0; saw_done = 0;
        first = '0; last = '0; prev = '0;
        for (int i = 0; i < 32; i++) seen[i] = 0;
        @(negedge clk);
        chk("idle_valid", int'(bus.stim_valid), 0);
        chk("idle_busy", int'(busy), 0);
        mode = m[1:0]; hold = HW'(h); seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (scramble) begin
                mode = 2'($urandom); hold = HW'($urandom); seed = W'($urandom);
            end
            if (busy) busy_cyc++;
            if (fin) begin
                chk("fin_done", int'(done), 1);
                chk("fin_valid", int'(bus.stim_valid), 0);
                chk("fin_busy", int'(busy), 0);
                chk("fin_stim_hold", int'(bus.stim), int'(last));
                saw_done = 1;
                @(negedge clk);
                chk("post_done", int'(done), 0);
                chk("post_stim_hold", int'(bus.stim), int'(last));
                break;
            end
            chk("run_done_low", int'(done), 0);
            chk("run_busy", int'(busy), 1);
            if (gap > 0) begin
                chk("gap_valid", int'(bus.stim_valid), 0);
                gap--;
                bus.stim_ready = 1'($urandom);
            end else begin
                chk("drv_valid", int'(bus.stim_valid), 1);
                chk("drv_stim", int'(bus.stim), int'(exp_q[k]));
                chk("drv_idx", int'(bus.vec_idx), k);
                rdy = ($urandom_range(99) < rpct);
                bus.stim_ready = rdy;
                if (rdy) begin
                    if (nx == 0) first = bus.stim;
                    else if (m == 1) chk("gray_onebit", $countones(prev ^ bus.stim), 1);
                    if (m == 3) begin
                        chk("lfsr_nonzero", int'(bus.stim != '0), 1);
                        chk("lfsr_norepeat", int'(seen[bus.stim]), 0);
                        seen[bus.stim] = 1;
                    end
                    prev = bus.stim; last = bus.stim; nx++;
                    if (k == exp_q.size() - 1) fin = 1;
                    else begin k++; gap = h; end
                end
            end
            @(negedge clk);
        end
        chk("run_reached_done", int'(saw_done), 1);
        bus.stim_ready = 1'b0;
        mode = 2'd0; hold = '0; seed = '0;
    endtask

    task automatic wait_done(input string nm);
        bit seen_done = 0;
        bus.stim_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin seen_done = 1; break; end
        end
        chk(nm, int'(seen_done), 1);
        bus.stim_ready = 1'b0;
    endtask

    vec_t         tbl[7];
    int           nx, bc;
    logic [W-1:0] fv, lv;
    int           e;

    initial begin
        bus.stim_ready = 1'b0;
        tbl[0] = '{m:0, h:0,   sd:5'd0, scramble:0, n:32, first:5'd0, last:5'd31, busy_cyc:32};
        tbl[1] = '{m:1, h:2,   sd:5'd0, scramble:1, n:32, first:5'd0, last:5'd16, busy_cyc:94};
        tbl[2] = '{m:2, h:0,   sd:5'd0, scramble:0, n:5,  first:5'd1, last:5'd16, busy_cyc:5};
        tbl[3] = '{m:3, h:0,   sd:5'd0, scramble:0, n:31, first:5'd1, last:5'd16, busy_cyc:31};
        tbl[4] = '{m:3, h:1,   sd:5'd7, scramble:1, n:31, first:5'd7, last:5'd19, busy_cyc:61};
        tbl[5] = '{m:0, h:3,   sd:5'd9, scramble:0, n:32, first:5'd0, last:5'd31, busy_cyc:125};
        tbl[6] = '{m:2, h:255, sd:5'd0, scramble:0, n:5,  first:5'd1, last:5'd16, busy_cyc:1025};

        // Reset state
        #1;
        chk("rst_stim", int'(bus.stim), 0);
        chk("rst_valid", int'(bus.stim_valid), 0);
        chk("rst_idx", int'(bus.vec_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            run_seq(tbl[i].m, tbl[i].h, tbl[i].sd, 100, tbl[i].scramble, nx, fv, lv, bc);
            chk($sformatf("tbl%0d_count", i), nx, tbl[i].n);
            chk($sformatf("tbl%0d_first", i), int'(fv), int'(tbl[i].first));
            chk($sformatf("tbl%0d_last", i), int'(lv), int'(tbl[i].last));
            chk($sformatf("tbl%0d_busy", i), bc, tbl[i].busy_cyc);
        end

        // Randomised runs with back-pressure and mid-run input churn
        for (int r = 0; r < 12; r++) begin
            int rm, rh;
            rm = $urandom_range(3);
            rh = $urandom_range(3);
            run_seq(rm, rh, W'($urandom), $urandom_range(100, 40), 1, nx, fv, lv, bc);
            chk($sformatf("rnd%0d_count", r), nx, exp_q.size());
        end

        // Back-pressure: ready low for 3 cycles while stim=7
        @(negedge clk);
        mode = 2'd0; hold = '0; start = 1'b1; bus.stim_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !(bus.stim_valid && bus.stim == 5'd7); i++) @(negedge clk);
        bus.stim_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_stim", int'(bus.stim), 7);
            chk("stall_idx", int'(bus.vec_idx), 7);
            chk("stall_valid", int'(bus.stim_valid), 1);
            if (i < 2) @(negedge clk);
        end
        bus.stim_ready = 1'b1;
        @(negedge clk);
        chk("after_stall_stim", int'(bus.stim), 8);
        chk("after_stall_idx", int'(bus.vec_idx), 8);
        wait_done("stall_run_done");

        // Asynchronous reset mid-run; start pulsed mid-run is ignored
        @(negedge clk);
        mode = 2'd0; hold = '0; start = 1'b1; bus.stim_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        for (int i = 0; i < 40 && e < 10; i++) begin
            chk("mid_stim", int'(bus.stim), e);
            chk("mid_idx", int'(bus.vec_idx), e);
            start = (e == 3);
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("pre_rst_idx", int'(bus.vec_idx), 10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stim", int'(bus.stim), 0);
        chk("async_rst_idx", int'(bus.vec_idx), 0);
        chk("async_rst_valid", int'(bus.stim_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_valid", int'(bus.stim_valid), 1);
        chk("restart_stim", int'(bus.stim), 0);
        chk("restart_idx", int'(bus.vec_idx), 0);
        wait_done("restart_run_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
